// File: rtl/rtc_access_scheduler.sv
// Access scheduler for the RTC read/write engine: latches user and periodic read
// requests and grants them one at a time as single-cycle command pulses.
module rtc_access_scheduler #(
  parameter int unsigned READ_PERIOD = 1_000_000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned TO_W        = 13,
  parameter int unsigned GUARD       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_hora,
  input  logic       req_fecha,
  input  logic       req_timer,
  input  logic       req_stop_ring,
  input  logic       req_act_timer,
  input  logic       req_leer,
  input  logic       ready,
  input  logic       clr_err,
  output logic       leer,
  output logic       esc_hora,
  output logic       esc_fecha,
  output logic       esc_timer,
  output logic       stop_ring,
  output logic       inic,
  output logic       act_timer,
  output logic       busy,
  output logic [6:0] pend,
  output logic       err_timeout,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  // Bit positions inside the pending mask, highest index = highest priority.
  localparam int P_INIC  = 6;
  localparam int P_STOP  = 5;
  localparam int P_HORA  = 4;
  localparam int P_FECHA = 3;
  localparam int P_TIMER = 2;
  localparam int P_ACT   = 1;
  localparam int P_LEER  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [6:0]      r_pend;
  logic [6:0]      r_cmd;
  logic [6:0]      w_grant;
  logic [6:0]      w_req_set;
  logic [CNT_W-1:0] r_per_cnt;
  logic            w_wrap;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;
  logic [GW-1:0]   r_gap_cnt;
  logic [GW-1:0]   w_gap_nxt;
  logic            w_err_set;
  logic            r_err;

  assign w_wrap = (r_per_cnt == CNT_W'(READ_PERIOD - 1));

  assign w_req_set = {1'b0, req_stop_ring, req_hora, req_fecha,
                      req_timer, req_act_timer, req_leer | w_wrap};

  // Fixed-priority pick of one pending bit, only offered while idle.
  always_comb begin
    w_grant = '0;
    if (r_state == S_IDLE) begin
      if      (r_pend[P_INIC])  w_grant[P_INIC]  = 1'b1;
      else if (r_pend[P_STOP])  w_grant[P_STOP]  = 1'b1;
      else if (r_pend[P_HORA])  w_grant[P_HORA]  = 1'b1;
      else if (r_pend[P_FECHA]) w_grant[P_FECHA] = 1'b1;
      else if (r_pend[P_TIMER]) w_grant[P_TIMER] = 1'b1;
      else if (r_pend[P_ACT])   w_grant[P_ACT]   = 1'b1;
      else if (r_pend[P_LEER])  w_grant[P_LEER]  = 1'b1;
    end
  end

  // Engine handshake: a command pulse starts an operation; the engine answers with a
  // one-cycle ready. A ready coinciding with the pulse cycle (r_cmd != 0) is stale.
  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_state_nxt = S_WAIT;
          w_to_nxt    = '0;
        end
      end
      S_WAIT: begin
        if (ready && !(|r_cmd)) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_err_set   = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GUARD - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pend    <= 7'b1000000;
      r_cmd     <= '0;
      r_per_cnt <= '0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_grant;
      // Set after clear so a request landing on its own grant edge is kept.
      r_pend    <= (r_pend & ~w_grant) | w_req_set;
      r_per_cnt <= w_wrap ? '0 : r_per_cnt + 1'b1;
      r_to_cnt  <= w_to_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_err_set)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  assign inic        = r_cmd[P_INIC];
  assign stop_ring   = r_cmd[P_STOP];
  assign esc_hora    = r_cmd[P_HORA];
  assign esc_fecha   = r_cmd[P_FECHA];
  assign esc_timer   = r_cmd[P_TIMER];
  assign act_timer   = r_cmd[P_ACT];
  assign leer        = r_cmd[P_LEER];
  assign busy        = (r_state != S_IDLE);
  assign pend        = r_pend;
  assign err_timeout = r_err;
  assign o_dbg_state = r_state;

endmodule
